// File: rtl/cdb_arbiter.sv
// Shares the CDB between ALU and LSB through per-producer result FIFOs and a round-robin pop.
// Define CDB_BYPASS_EN to let a result reach the CDB one cycle after it arrives, when both FIFOs are empty.
module cdb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ROB_IDX_W  = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clr_in,
   input  logic                 alu_valid,
   input  logic [ROB_IDX_W-1:0] alu_rob_index,
   input  logic [DATA_W-1:0]    alu_result,
   output logic                 alu_accept,
   input  logic                 lsb_valid,
   input  logic [ROB_IDX_W-1:0] lsb_rob_index,
   input  logic [DATA_W-1:0]    lsb_result,
   output logic                 lsb_accept,
   output logic                 cdb_valid,
   output logic [ROB_IDX_W-1:0] cdb_rob_index,
   output logic [DATA_W-1:0]    cdb_result,
   output logic                 cdb_src,
   output logic [CNT_W-1:0]     alu_cnt,
   output logic [CNT_W-1:0]     lsb_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = ROB_IDX_W + DATA_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LSB = 1'b1;

   logic [ENT_W-1:0] alu_mem [FIFO_DEPTH];
   logic [ENT_W-1:0] lsb_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
   logic             last_grant;

   logic active;
   logic alu_push, lsb_push, alu_ne, lsb_ne;
   logic alu_pop, lsb_pop, alu_byp, lsb_byp, alu_wr, lsb_wr;

   // Accept is based on registered occupancy only, so a same-cycle pop never frees a slot.
   assign active     = rdy_in & ~clr_in;
   assign alu_accept = rst_in & active & (alu_cnt != FULL_CNT);
   assign lsb_accept = rst_in & active & (lsb_cnt != FULL_CNT);
   assign alu_push   = alu_valid & alu_accept;
   assign lsb_push   = lsb_valid & lsb_accept;
   assign alu_ne     = (alu_cnt != '0);
   assign lsb_ne     = (lsb_cnt != '0);

   assign alu_pop = active & alu_ne & (~lsb_ne | (last_grant == SRC_LSB));
   assign lsb_pop = active & lsb_ne & (~alu_ne | (last_grant == SRC_ALU));

`ifdef CDB_BYPASS_EN
   logic alu_byp_ok, lsb_byp_ok;
   assign alu_byp_ok = alu_push & ~alu_ne & ~lsb_pop;
   assign lsb_byp_ok = lsb_push & ~lsb_ne & ~alu_pop;
   assign alu_byp    = alu_byp_ok & (~lsb_byp_ok | (last_grant == SRC_LSB));
   assign lsb_byp    = lsb_byp_ok & (~alu_byp_ok | (last_grant == SRC_ALU));
`else
   assign alu_byp = 1'b0;
   assign lsb_byp = 1'b0;
`endif

   assign alu_wr = alu_push & ~alu_byp;
   assign lsb_wr = lsb_push & ~lsb_byp;

   always_ff @(posedge clk_in) begin
      if (alu_wr) alu_mem[alu_tail] <= {alu_rob_index, alu_result};
      if (lsb_wr) lsb_mem[lsb_tail] <= {lsb_rob_index, lsb_result};
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         alu_head      <= '0;
         alu_tail      <= '0;
         lsb_head      <= '0;
         lsb_tail      <= '0;
         alu_cnt       <= '0;
         lsb_cnt       <= '0;
         last_grant    <= SRC_LSB;
         cdb_valid     <= 1'b0;
         cdb_rob_index <= '0;
         cdb_result    <= '0;
         cdb_src       <= 1'b0;
      end else if (clr_in) begin
         alu_head   <= '0;
         alu_tail   <= '0;
         lsb_head   <= '0;
         lsb_tail   <= '0;
         alu_cnt    <= '0;
         lsb_cnt    <= '0;
         last_grant <= SRC_LSB;
         cdb_valid  <= 1'b0;
      end else if (!rdy_in) begin
         cdb_valid <= 1'b0;
      end else begin
         if (alu_wr)  alu_tail <= alu_tail + 1'b1;
         if (alu_pop) alu_head <= alu_head + 1'b1;
         if (lsb_wr)  lsb_tail <= lsb_tail + 1'b1;
         if (lsb_pop) lsb_head <= lsb_head + 1'b1;
         alu_cnt   <= alu_cnt + CNT_W'(alu_wr) - CNT_W'(alu_pop);
         lsb_cnt   <= lsb_cnt + CNT_W'(lsb_wr) - CNT_W'(lsb_pop);
         cdb_valid <= 1'b0;
         if (alu_pop) begin
            {cdb_rob_index, cdb_result} <= alu_mem[alu_head];
            cdb_src    <= SRC_ALU;
            cdb_valid  <= 1'b1;
            last_grant <= SRC_ALU;
         end else if (lsb_pop) begin
            {cdb_rob_index, cdb_result} <= lsb_mem[lsb_head];
            cdb_src    <= SRC_LSB;
            cdb_valid  <= 1'b1;
            last_grant <= SRC_LSB;
         end else if (alu_byp) begin
            cdb_rob_index <= alu_rob_index;
            cdb_result    <= alu_result;
            cdb_src       <= SRC_ALU;
            cdb_valid     <= 1'b1;
            last_grant    <= SRC_ALU;
         end else if (lsb_byp) begin
            cdb_rob_index <= lsb_rob_index;
            cdb_result    <= lsb_result;
            cdb_src       <= SRC_LSB;
            cdb_valid     <= 1'b1;
            last_grant    <= SRC_LSB;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, checked against a queue-based model.
// The model follows CDB_BYPASS_EN the same way the design does.
module tb_cdb_arbiter;

   localparam int DATA_W     = 32;
   localparam int ROB_IDX_W  = 4;
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W      = ROB_IDX_W + DATA_W;

   logic                 clk_in = 1'b0;
   logic                 rst_in, rdy_in, clr_in;
   logic                 alu_valid, lsb_valid;
   logic [ROB_IDX_W-1:0] alu_rob_index, lsb_rob_index;
   logic [DATA_W-1:0]    alu_result, lsb_result;
   logic                 alu_accept, lsb_accept;
   logic                 cdb_valid, cdb_src;
   logic [ROB_IDX_W-1:0] cdb_rob_index;
   logic [DATA_W-1:0]    cdb_result;
   logic [CNT_W-1:0]     alu_cnt, lsb_cnt;

   cdb_arbiter #(.DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
      .alu_valid(alu_valid), .alu_rob_index(alu_rob_index), .alu_result(alu_result),
      .alu_accept(alu_accept),
      .lsb_valid(lsb_valid), .lsb_rob_index(lsb_rob_index), .lsb_result(lsb_result),
      .lsb_accept(lsb_accept),
      .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_result(cdb_result),
      .cdb_src(cdb_src), .alu_cnt(alu_cnt), .lsb_cnt(lsb_cnt)
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_bad = 0;

   // Reference state: one queue per producer plus the visible CDB registers.
   logic [ENT_W-1:0]     q_alu[$];
   logic [ENT_W-1:0]     q_lsb[$];
   logic                 m_lg;
   logic                 m_valid, m_src;
   logic [ROB_IDX_W-1:0] m_idx;
   logic [DATA_W-1:0]    m_res;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      q_alu.delete();
      q_lsb.delete();
      m_lg    = 1'b1;
      m_valid = 1'b0;
      m_src   = 1'b0;
      m_idx   = '0;
      m_res   = '0;
   endtask

   task automatic checkCdb(input string tag);
      checkOutput({tag, ".cdb_valid"}, cdb_valid, m_valid);
      checkOutput({tag, ".cdb_rob_index"}, cdb_rob_index, m_idx);
      checkOutput({tag, ".cdb_result"}, cdb_result, m_res);
      checkOutput({tag, ".cdb_src"}, cdb_src, m_src);
      checkOutput({tag, ".alu_cnt"}, alu_cnt, q_alu.size());
      checkOutput({tag, ".lsb_cnt"}, lsb_cnt, q_lsb.size());
   endtask

   task automatic modelStep(input logic av, input logic [ROB_IDX_W-1:0] ai, input logic [DATA_W-1:0] ar,
                            input logic lv, input logic [ROB_IDX_W-1:0] li, input logic [DATA_W-1:0] lr,
                            input logic rdy, input logic clr);
      logic pa, pl;
      if (clr) begin
         q_alu.delete();
         q_lsb.delete();
         m_valid = 1'b0;
         m_lg    = 1'b1;
      end else if (!rdy) begin
         m_valid = 1'b0;
      end else begin
         pa = av && (q_alu.size() < FIFO_DEPTH);
         pl = lv && (q_lsb.size() < FIFO_DEPTH);
         m_valid = 1'b0;
         if (q_alu.size() > 0 || q_lsb.size() > 0) begin
            if (q_alu.size() > 0 && (q_lsb.size() == 0 || m_lg == 1'b1)) begin
               {m_idx, m_res} = q_alu.pop_front();
               m_src = 1'b0;
            end else begin
               {m_idx, m_res} = q_lsb.pop_front();
               m_src = 1'b1;
            end
            m_lg    = m_src;
            m_valid = 1'b1;
         end
`ifdef CDB_BYPASS_EN
         else if (pa && (!pl || m_lg == 1'b1)) begin
            m_idx = ai; m_res = ar; m_src = 1'b0; m_lg = 1'b0; m_valid = 1'b1; pa = 1'b0;
         end else if (pl) begin
            m_idx = li; m_res = lr; m_src = 1'b1; m_lg = 1'b1; m_valid = 1'b1; pl = 1'b0;
         end
`endif
         if (pa) q_alu.push_back({ai, ar});
         if (pl) q_lsb.push_back({li, lr});
      end
   endtask

   // One clock cycle: drive inputs, check accepts before the edge, advance the model, check after the edge.
   task automatic applyStimulus(input string tag,
                                input logic av, input logic [ROB_IDX_W-1:0] ai, input logic [DATA_W-1:0] ar,
                                input logic lv, input logic [ROB_IDX_W-1:0] li, input logic [DATA_W-1:0] lr,
                                input logic rdy, input logic clr);
      alu_valid = av; alu_rob_index = ai; alu_result = ar;
      lsb_valid = lv; lsb_rob_index = li; lsb_result = lr;
      rdy_in = rdy; clr_in = clr;
      #1;
      checkOutput({tag, ".alu_accept"}, alu_accept, rdy && !clr && (q_alu.size() < FIFO_DEPTH));
      checkOutput({tag, ".lsb_accept"}, lsb_accept, rdy && !clr && (q_lsb.size() < FIFO_DEPTH));
      modelStep(av, ai, ar, lv, li, lr, rdy, clr);
      @(posedge clk_in);
      #1;
      checkCdb(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) applyStimulus(tag, 0, '0, '0, 0, '0, '0, 1, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      rst_in = 1'b0; rdy_in = 1'b0; clr_in = 1'b0;
      alu_valid = 1'b0; alu_rob_index = '0; alu_result = '0;
      lsb_valid = 1'b0; lsb_rob_index = '0; lsb_result = '0;
      modelReset();
      #12;
      rdy_in = 1'b1;
      #1;
      checkCdb("reset");
      checkOutput("reset.alu_accept", alu_accept, 0);
      checkOutput("reset.lsb_accept", lsb_accept, 0);
      @(posedge clk_in);
      #3;
      rst_in = 1'b1;

      // Single uncontended ALU result.
      applyStimulus("single", 1, 4'd3, 32'h11, 0, '0, '0, 1, 0);
      idle("single_idle", 3);

      // Ties: first goes to ALU, the next one to LSB.
      applyStimulus("tie1", 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 0);
      idle("tie1_idle", 3);
      applyStimulus("tie2", 1, 4'd5, 32'hA5, 1, 4'd6, 32'hB6, 1, 0);
      idle("tie2_idle", 3);

      // ALU pushes back-to-back while LSB keeps its FIFO busy.
      for (int i = 0; i < 4; i++)
         applyStimulus("bp", 1, ROB_IDX_W'(i + 1), DATA_W'(32'h100 + i), 1, ROB_IDX_W'(i + 9), DATA_W'(32'h200 + i), 1, 0);
      idle("bp_idle", 6);

      // Stall with both FIFOs loaded, then resume.
      applyStimulus("stall_fill", 1, 4'd7, 32'h77, 1, 4'd8, 32'h88, 1, 0);
      applyStimulus("stall_fill", 1, 4'd9, 32'h99, 1, 4'd10, 32'hAA, 1, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus("stall", 1, 4'd11, 32'hBB, 1, 4'd12, 32'hCC, 0, 0);
      idle("resume", 5);

      // Flush with buffered entries and a new LSB result in the flush cycle.
      applyStimulus("clr_fill", 1, 4'd13, 32'hD1, 1, 4'd14, 32'hD2, 1, 0);
      applyStimulus("clr_fill", 1, 4'd15, 32'hD3, 0, '0, '0, 1, 0);
      applyStimulus("clr_fill", 1, 4'd13, 32'hD4, 0, '0, '0, 1, 0);
      applyStimulus("clr", 1, 4'd15, 32'hE1, 1, 4'd14, 32'hE2, 1, 1);
      idle("clr_idle", 3);

      // Random traffic.
      for (int i = 0; i < 500; i++)
         applyStimulus("rand",
                       1'($urandom_range(0, 1)), ROB_IDX_W'($urandom_range(1, 15)), DATA_W'($urandom),
                       1'($urandom_range(0, 1)), ROB_IDX_W'($urandom_range(1, 15)), DATA_W'($urandom),
                       1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 29) == 0));

      // Asynchronous reset while a broadcast is on the bus.
      applyStimulus("arst_clr", 0, '0, '0, 0, '0, '0, 1, 1);
      applyStimulus("arst_push", 1, 4'd4, 32'h44, 1, 4'd5, 32'h55, 1, 0);
      guard = 0;
      while (!m_valid && guard < 8) begin
         idle("arst_wait", 1);
         guard++;
      end
      checkOutput("arst.precondition", cdb_valid, 1);
      #2;
      rst_in = 1'b0;
      modelReset();
      #1;
      checkCdb("arst");
      checkOutput("arst.alu_accept", alu_accept, 0);
      checkOutput("arst.lsb_accept", lsb_accept, 0);
      #1;
      rst_in = 1'b1;
      applyStimulus("post_arst", 1, 4'd3, 32'h33, 0, '0, '0, 1, 0);
      idle("post_arst_idle", 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
